// File: rtl/eth_pkg.sv
`default_nettype none
// ============================================================================
// Module   : eth_pkg
// Purpose  : Shared Ethernet receive/transmit constants, state encoding and
//            the reflected CRC-32 byte-step function.
// Revision : 1.0
// ============================================================================
package eth_pkg;

    localparam logic [2:0] ERR_OK     = 3'd0;
    localparam logic [2:0] ERR_PHY    = 3'd1;
    localparam logic [2:0] ERR_FILTER = 3'd2;
    localparam logic [2:0] ERR_RUNT   = 3'd3;
    localparam logic [2:0] ERR_LONG   = 3'd4;
    localparam logic [2:0] ERR_CRC    = 3'd5;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    localparam logic [31:0] CRC_INIT           = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_POLY_REFLECTED = 32'hEDB88320;
    // Residue in MSB-first notation; the reflected register holds its bit-reverse.
    localparam logic [31:0] CRC_RESIDUE        = 32'hC704DD7B;

    localparam int HDR_BYTES     = 18;
    localparam int APP_HDR_BYTES = 4;
    localparam int FCS_BYTES     = 4;
    localparam int PRE_MAX       = 7;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_HDR  = 3'd2,
        ST_PAY  = 3'd3,
        ST_FCS  = 3'd4,
        ST_TAIL = 3'd5,
        ST_DROP = 3'd6
    } rx_state_e;

    function automatic logic [31:0] crc32_next(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'h000000, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFLECTED) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [31:0] bitrev32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = x[31-i];
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/crc32_byte.sv
`default_nettype none
// ============================================================================
// Module   : crc32_byte
// Purpose  : Combinational IEEE 802.3 reflected CRC-32 update for one byte.
// Revision : 1.0
// ============================================================================
module crc32_byte (
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);
    import eth_pkg::*;

    assign crc_o = crc32_next(crc_i, data_i);

endmodule

`default_nettype wire

// File: rtl/rx_frame_parser.sv
`default_nettype none
// ============================================================================
// Module   : rx_frame_parser
// Purpose  : Receive frame parser: preamble/SFD delineation, dst-MAC and
//            EtherType filter, app-header extraction, indexed payload stream
//            and per-frame FCS verdict.
// Revision : 1.0
// ============================================================================
module rx_frame_parser #(
    parameter logic [47:0] MY_MAC        = 48'h000A35000102,
    parameter logic [15:0] ETHERTYPE     = 16'h88B5,
    parameter int          PAYLOAD_BYTES = 1024
) (
    input  logic        clk125MHz,
    input  logic        rstb,
    input  logic [7:0]  data,
    input  logic        data_valid,
    input  logic        data_enable,
    input  logic        data_error,
    output logic        hdr_valid,
    output logic [15:0] segment_num,
    output logic [7:0]  txid,
    output logic [7:0]  aux,
    output logic [7:0]  pay_data,
    output logic        pay_valid,
    output logic [11:0] pay_index,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [2:0]  err_code
);
    import eth_pkg::*;

    localparam logic [4:0]  HDR_LAST = 5'(HDR_BYTES - 1);
    localparam logic [11:0] PAY_LAST = 12'(PAYLOAD_BYTES - 1);
    localparam logic [1:0]  FCS_LAST = 2'(FCS_BYTES - 1);
    localparam logic [2:0]  PRE_LAST = 3'(PRE_MAX);

    rx_state_e   state_q;
    logic        en_q;
    logic        sfd_q;
    logic        phy_q;
    logic        filt_q;
    logic        long_q;
    logic [2:0]  pre_cnt_q;
    logic [4:0]  hcnt_q;
    logic [11:0] pcnt_q;
    logic [1:0]  fcnt_q;
    logic [31:0] crc_q;
    logic [39:0] hdr_sr_q;

    logic        hdr_valid_q;
    logic [15:0] segment_num_q;
    logic [7:0]  txid_q;
    logic [7:0]  aux_q;
    logic [7:0]  pay_data_q;
    logic        pay_valid_q;
    logic [11:0] pay_index_q;
    logic        frame_done_q;
    logic        frame_ok_q;
    logic [2:0]  err_code_q;

    logic        acc;
    logic        eof;
    logic [31:0] crc_d;
    logic [47:0] dst_word;
    logic        dst_ok;
    logic        type_ok;
    logic        crc_good;
    logic [2:0]  err_d;

    assign acc      = data_enable & data_valid;
    assign eof      = en_q & ~data_enable;
    assign dst_word = {hdr_sr_q, data};
    assign dst_ok   = (dst_word == MY_MAC) || (dst_word == 48'hFFFFFFFFFFFF);
    assign type_ok  = ({hdr_sr_q[7:0], data} == ETHERTYPE);
    assign crc_good = (bitrev32(crc_q) == CRC_RESIDUE);

    crc32_byte u_crc (
        .crc_i  (crc_q),
        .data_i (data),
        .crc_o  (crc_d)
    );

    // Priority of the end-of-frame verdict: PHY > FILTER > RUNT > LONG > CRC.
    always_comb begin
        err_d = ERR_OK;
        if (phy_q) begin
            err_d = ERR_PHY;
        end else if (filt_q) begin
            err_d = ERR_FILTER;
        end else if (state_q != ST_TAIL) begin
            err_d = ERR_RUNT;
        end else if (long_q) begin
            err_d = ERR_LONG;
        end else if (!crc_good) begin
            err_d = ERR_CRC;
        end
    end

    always_ff @(posedge clk125MHz or negedge rstb) begin
        if (!rstb) begin
            state_q       <= ST_IDLE;
            en_q          <= 1'b0;
            sfd_q         <= 1'b0;
            phy_q         <= 1'b0;
            filt_q        <= 1'b0;
            long_q        <= 1'b0;
            pre_cnt_q     <= 3'd0;
            hcnt_q        <= 5'd0;
            pcnt_q        <= 12'd0;
            fcnt_q        <= 2'd0;
            crc_q         <= CRC_INIT;
            hdr_sr_q      <= 40'd0;
            hdr_valid_q   <= 1'b0;
            segment_num_q <= 16'd0;
            txid_q        <= 8'd0;
            aux_q         <= 8'd0;
            pay_data_q    <= 8'd0;
            pay_valid_q   <= 1'b0;
            pay_index_q   <= 12'd0;
            frame_done_q  <= 1'b0;
            frame_ok_q    <= 1'b0;
            err_code_q    <= ERR_OK;
        end else begin
            en_q         <= data_enable;
            hdr_valid_q  <= 1'b0;
            pay_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;

            if (eof) begin
                // Only frames that reached SFD report a verdict.
                if (sfd_q) begin
                    frame_done_q <= 1'b1;
                    err_code_q   <= err_d;
                    frame_ok_q   <= (err_d == ERR_OK);
                end
                state_q   <= ST_IDLE;
                sfd_q     <= 1'b0;
                phy_q     <= 1'b0;
                filt_q    <= 1'b0;
                long_q    <= 1'b0;
                pre_cnt_q <= 3'd0;
                hcnt_q    <= 5'd0;
                pcnt_q    <= 12'd0;
                fcnt_q    <= 2'd0;
            end else if (data_enable && data_error && (state_q != ST_IDLE)) begin
                phy_q   <= 1'b1;
                state_q <= ST_DROP;
            end else if (acc) begin
                case (state_q)
                    ST_IDLE: begin
                        if (data == PREAMBLE_BYTE) begin
                            state_q   <= ST_PRE;
                            pre_cnt_q <= 3'd1;
                        end
                    end
                    ST_PRE: begin
                        if (data == SFD_BYTE) begin
                            state_q <= ST_HDR;
                            sfd_q   <= 1'b1;
                            crc_q   <= CRC_INIT;
                            hcnt_q  <= 5'd0;
                        end else if ((data == PREAMBLE_BYTE) && (pre_cnt_q != PRE_LAST)) begin
                            pre_cnt_q <= pre_cnt_q + 3'd1;
                        end else begin
                            state_q <= ST_DROP;
                        end
                    end
                    ST_HDR: begin
                        crc_q    <= crc_d;
                        hdr_sr_q <= {hdr_sr_q[31:0], data};
                        hcnt_q   <= hcnt_q + 5'd1;
                        if (((hcnt_q == 5'd5) && !dst_ok) || ((hcnt_q == 5'd13) && !type_ok)) begin
                            filt_q  <= 1'b1;
                            state_q <= ST_DROP;
                        end else if (hcnt_q == HDR_LAST) begin
                            // Shift register holds app bytes 0..2; byte 3 is on the bus.
                            hdr_valid_q   <= 1'b1;
                            segment_num_q <= hdr_sr_q[23:8];
                            txid_q        <= hdr_sr_q[7:0];
                            aux_q         <= data;
                            pcnt_q        <= 12'd0;
                            state_q       <= ST_PAY;
                        end
                    end
                    ST_PAY: begin
                        crc_q       <= crc_d;
                        pay_data_q  <= data;
                        pay_valid_q <= 1'b1;
                        pay_index_q <= pcnt_q;
                        pcnt_q      <= pcnt_q + 12'd1;
                        if (pcnt_q == PAY_LAST) begin
                            fcnt_q  <= 2'd0;
                            state_q <= ST_FCS;
                        end
                    end
                    ST_FCS: begin
                        crc_q  <= crc_d;
                        fcnt_q <= fcnt_q + 2'd1;
                        if (fcnt_q == FCS_LAST) begin
                            state_q <= ST_TAIL;
                        end
                    end
                    ST_TAIL: begin
                        long_q <= 1'b1;
                    end
                    ST_DROP: begin
                        state_q <= ST_DROP;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign hdr_valid   = hdr_valid_q;
    assign segment_num = segment_num_q;
    assign txid        = txid_q;
    assign aux         = aux_q;
    assign pay_data    = pay_data_q;
    assign pay_valid   = pay_valid_q;
    assign pay_index   = pay_index_q;
    assign frame_done  = frame_done_q;
    assign frame_ok    = frame_ok_q;
    assign err_code    = err_code_q;

endmodule

`default_nettype wire

// File: tb/tb_rx_frame_parser.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_rx_frame_parser
// Purpose  : Self-checking bench for rx_frame_parser with a frame-level
//            reference model.
// Revision : 1.0
// ============================================================================
module tb_rx_frame_parser;

    localparam logic [47:0] MAC   = 48'h000A35000102;
    localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;
    localparam logic [47:0] OTHER = 48'h001122334455;
    localparam logic [15:0] ETYPE = 16'h88B5;
    localparam int          P     = 1024;

    logic        clk125MHz   = 1'b0;
    logic        rstb        = 1'b0;
    logic [7:0]  data        = 8'h00;
    logic        data_valid  = 1'b0;
    logic        data_enable = 1'b0;
    logic        data_error  = 1'b0;
    logic        hdr_valid;
    logic [15:0] segment_num;
    logic [7:0]  txid;
    logic [7:0]  aux;
    logic [7:0]  pay_data;
    logic        pay_valid;
    logic [11:0] pay_index;
    logic        frame_done;
    logic        frame_ok;
    logic [2:0]  err_code;

    always #4 clk125MHz = ~clk125MHz;

    rx_frame_parser #(
        .MY_MAC        (MAC),
        .ETHERTYPE     (ETYPE),
        .PAYLOAD_BYTES (P)
    ) dut (
        .clk125MHz   (clk125MHz),
        .rstb        (rstb),
        .data        (data),
        .data_valid  (data_valid),
        .data_enable (data_enable),
        .data_error  (data_error),
        .hdr_valid   (hdr_valid),
        .segment_num (segment_num),
        .txid        (txid),
        .aux         (aux),
        .pay_data    (pay_data),
        .pay_valid   (pay_valid),
        .pay_index   (pay_index),
        .frame_done  (frame_done),
        .frame_ok    (frame_ok),
        .err_code    (err_code)
    );

    int         errors = 0;
    int         checks = 0;
    longint     cyc    = 0;
    logic [7:0] fr[$];
    logic [31:0] mon_hdr[$];
    logic [19:0] mon_pay[$];
    longint      mon_pt[$];
    logic [3:0]  mon_fd[$];

    always @(negedge clk125MHz) begin
        cyc = cyc + 1;
        if (hdr_valid)  mon_hdr.push_back({segment_num, txid, aux});
        if (pay_valid)  begin
            mon_pay.push_back({pay_index, pay_data});
            mon_pt.push_back(cyc);
        end
        if (frame_done) mon_fd.push_back({frame_ok, err_code});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk125MHz);
        #1;
    endtask

    task automatic clear_mon();
        mon_hdr.delete();
        mon_pay.delete();
        mon_pt.delete();
        mon_fd.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        @(negedge clk125MHz);
        check(tag, {5'd0, hdr_valid, segment_num, txid, aux, pay_data, pay_valid,
                    pay_index, frame_done, frame_ok, err_code}, 64'd0);
    endtask

    // Standard Ethernet FCS over fr[0..n-1] (value sent LSB byte first).
    function automatic logic [31:0] eth_crc(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h000000, fr[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic build(input logic [47:0] dst, input logic [15:0] ty, input logic [15:0] seg,
                         input logic [7:0] tx, input logic [7:0] ax, input bit rnd);
        logic [31:0] c;
        fr.delete();
        for (int i = 5; i >= 0; i--) fr.push_back(dst[8*i +: 8]);
        for (int i = 0; i < 6; i++) fr.push_back((i == 0) ? 8'h02 : 8'(i));
        fr.push_back(ty[15:8]);
        fr.push_back(ty[7:0]);
        fr.push_back(seg[15:8]);
        fr.push_back(seg[7:0]);
        fr.push_back(tx);
        fr.push_back(ax);
        for (int k = 0; k < P; k++) fr.push_back(rnd ? 8'($urandom) : 8'(k));
        c = eth_crc(fr.size());
        for (int i = 0; i < 4; i++) fr.push_back(c[8*i +: 8]);
    endtask

    task automatic send(input int gap, input int err_at);
        int n;
        n = fr.size() + 8;
        for (int i = 0; i < n; i++) begin
            data        = (i < 7) ? 8'h55 : ((i == 7) ? 8'hD5 : fr[i-8]);
            data_valid  = 1'b1;
            data_enable = 1'b1;
            data_error  = (err_at >= 0) && (i - 8 == err_at);
            tick();
            data_valid = 1'b0;
            data_error = 1'b0;
            for (int g = 1; g < gap; g++) begin
                data = 8'($urandom);
                tick();
            end
        end
        data_enable = 1'b0;
        data_valid  = 1'b0;
        repeat (8) tick();
    endtask

    // Frame-level reference: expected header, payload slice and verdict.
    task automatic run_frame(input string tag, input int gap, input int err_at);
        logic [47:0] dst;
        logic [15:0] ty;
        logic [31:0] fcs;
        int          n, cut, npay, exp_err, bad_gap;
        bit          filt, hdr_exp;
        clear_mon();
        send(gap, err_at);
        n   = fr.size();
        cut = (err_at >= 0) ? err_at : n;
        dst = '0;
        for (int i = 0; i < 6; i++) dst = {dst[39:0], fr[i]};
        ty      = {fr[12], fr[13]};
        filt    = (cut > 5) && (((dst != MAC) && (dst != BCAST)) || ((cut > 13) && (ty != ETYPE)));
        hdr_exp = !filt && (cut >= 18);
        npay    = hdr_exp ? (((cut - 18) < P) ? (cut - 18) : P) : 0;
        if (err_at >= 0)          exp_err = 1;
        else if (filt)            exp_err = 2;
        else if (n < 22 + P)      exp_err = 3;
        else if (n > 22 + P)      exp_err = 4;
        else begin
            fcs     = {fr[21+P], fr[20+P], fr[19+P], fr[18+P]};
            exp_err = (eth_crc(18 + P) == fcs) ? 0 : 5;
        end

        check({tag, " hdr_count"}, 64'(mon_hdr.size()), 64'(hdr_exp));
        if (hdr_exp && mon_hdr.size() > 0)
            check({tag, " hdr_fields"}, 64'(mon_hdr[0]), 64'({fr[14], fr[15], fr[16], fr[17]}));
        check({tag, " pay_count"}, 64'(mon_pay.size()), 64'(npay));
        for (int k = 0; k < npay && k < mon_pay.size(); k++)
            check({tag, " pay_idx_data"}, 64'(mon_pay[k]), 64'({12'(k), fr[18+k]}));
        bad_gap = 0;
        for (int k = 1; k < mon_pt.size(); k++)
            if (mon_pt[k] - mon_pt[k-1] != longint'(gap)) bad_gap++;
        check({tag, " pay_spacing_errs"}, 64'(bad_gap), 64'd0);
        check({tag, " done_count"}, 64'(mon_fd.size()), 64'd1);
        if (mon_fd.size() > 0)
            check({tag, " ok_err"}, 64'(mon_fd[0]), 64'({exp_err == 0, 3'(exp_err)}));
    endtask

    initial begin
        int sel, mode, gap, err_at, keep;
        logic [47:0] rdst;
        logic [15:0] rty;

        repeat (3) tick();
        check_outputs_zero("reset_state");
        tick();
        rstb = 1'b1;
        repeat (4) tick();

        build(MAC, ETYPE, 16'h002A, 8'h07, 8'h03, 1'b0);
        run_frame("good", 1, -1);
        run_frame("good_100M", 10, -1);

        fr[18+300] = fr[18+300] ^ 8'h01;
        run_frame("bad_crc", 1, -1);

        build(OTHER, ETYPE, 16'h002A, 8'h07, 8'h03, 1'b0);
        run_frame("bad_dst", 1, -1);
        build(BCAST, ETYPE, 16'h1234, 8'h55, 8'hAA, 1'b0);
        run_frame("bcast", 1, -1);
        build(MAC, 16'h0800, 16'h0001, 8'h01, 8'h02, 1'b0);
        run_frame("bad_type", 1, -1);

        build(MAC, ETYPE, 16'h002A, 8'h07, 8'h03, 1'b0);
        while (fr.size() > 18 + 500) void'(fr.pop_back());
        run_frame("runt", 1, -1);
        build(MAC, ETYPE, 16'h002A, 8'h07, 8'h03, 1'b0);
        fr.push_back(8'h12);
        fr.push_back(8'h34);
        run_frame("long", 1, -1);
        build(MAC, ETYPE, 16'h002A, 8'h07, 8'h03, 1'b0);
        run_frame("phy_hdr3", 1, 3);

        // Reset in the middle of the payload, then the remainder of the frame.
        build(MAC, ETYPE, 16'h0BEE, 8'h09, 8'h04, 1'b0);
        for (int i = 0; i < 8 + 18 + 200; i++) begin
            data        = (i < 7) ? 8'h55 : ((i == 7) ? 8'hD5 : fr[i-8]);
            data_valid  = 1'b1;
            data_enable = 1'b1;
            tick();
        end
        rstb = 1'b0;
        check_outputs_zero("midreset_zero_a");
        tick();
        check_outputs_zero("midreset_zero_b");
        tick();
        rstb = 1'b1;
        clear_mon();
        for (int i = 0; i < 20; i++) begin
            data = 8'h00;
            tick();
        end
        data_enable = 1'b0;
        data_valid  = 1'b0;
        repeat (8) tick();
        check("postreset_hdr", 64'(mon_hdr.size()), 64'd0);
        check("postreset_pay", 64'(mon_pay.size()), 64'd0);
        check("postreset_done", 64'(mon_fd.size()), 64'd0);
        build(MAC, ETYPE, 16'h002A, 8'h07, 8'h03, 1'b0);
        run_frame("after_reset", 1, -1);

        for (int t = 0; t < 4; t++) begin
            sel  = $urandom_range(0, 3);
            rdst = (sel == 1) ? BCAST : ((sel == 2) ? OTHER : MAC);
            rty  = ($urandom_range(0, 4) == 0) ? 16'h0800 : ETYPE;
            build(rdst, rty, 16'($urandom), 8'($urandom), 8'($urandom), 1'b1);
            mode = $urandom_range(0, 3);
            if (mode == 1) begin
                keep = 18 + $urandom_range(0, P - 1);
                fr[keep] = fr[keep] ^ 8'(1 << $urandom_range(0, 7));
            end else if (mode == 2) begin
                keep = $urandom_range(14, 18 + P + 3);
                while (fr.size() > keep) void'(fr.pop_back());
            end else if (mode == 3) begin
                fr.push_back(8'($urandom));
            end
            gap    = $urandom_range(1, 3);
            err_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, fr.size() - 1)) : -1;
            run_frame($sformatf("rand%0d", t), gap, err_at);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
